// File: rtl/obstacle_collision_checker.sv
// rtl/obstacle_collision_checker.sv - per-frame player/obstacle collision scan with lives and grace
// Snapshots obstacle boxes and player position, then tests one slot per cycle.
module obstacle_collision_checker #(
  parameter int NUM_OBSTACLES = 10,
  parameter int SCREEN_WIDTH  = 640,
  parameter int PLAYER_W      = 32,
  parameter int PLAYER_H      = 32,
  parameter int INIT_LIVES    = 3,
  parameter int GRACE_FRAMES  = 60
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_start,
  input  logic                           restart,
  input  logic [NUM_OBSTACLES-1:0][19:0] obstacle_x,
  input  logic [NUM_OBSTACLES-1:0][17:0] obstacle_y,
  input  logic [9:0]                     player_x,
  input  logic [8:0]                     player_y,
  output logic                           busy,
  output logic                           scan_done,
  output logic                           hit,
  output logic [3:0]                     hit_index,
  output logic [1:0]                     lives,
  output logic                           grace_active,
  output logic                           game_over
);

  localparam int GW = $clog2(GRACE_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, SNAP, SCAN, DONE} state_t;

  state_t                         state;
  logic [NUM_OBSTACLES-1:0][19:0] snap_x;
  logic [NUM_OBSTACLES-1:0][17:0] snap_y;
  logic [9:0]                     snap_px;
  logic [8:0]                     snap_py;
  logic [3:0]                     idx;
  logic [3:0]                     found_idx;
  logic                           found;
  logic [GW-1:0]                  grace_cnt;

  logic [9:0]  cur_left, cur_right;
  logic [8:0]  cur_top, cur_bottom;
  logic [10:0] px_end;
  logic [9:0]  py_end;
  logic        overlap;

  // Player far edges are widened by one bit so a box near the screen edge cannot wrap.
  always_comb begin
    cur_left   = snap_x[idx][19:10];
    cur_right  = snap_x[idx][9:0];
    cur_top    = snap_y[idx][17:9];
    cur_bottom = snap_y[idx][8:0];
    px_end     = {1'b0, snap_px} + 11'(PLAYER_W);
    py_end     = {1'b0, snap_py} + 10'(PLAYER_H);
    overlap    = (cur_left < 10'(SCREEN_WIDTH)) &&
                 (snap_px < cur_right) && (px_end > {1'b0, cur_left}) &&
                 (snap_py < cur_bottom) && (py_end > {1'b0, cur_top});
  end

  assign grace_active = (grace_cnt != '0);

  always_ff @(posedge clk) begin
    if (state == SNAP) begin
      snap_x  <= obstacle_x;
      snap_y  <= obstacle_y;
      snap_px <= player_x;
      snap_py <= player_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      scan_done <= 1'b0;
      hit       <= 1'b0;
      hit_index <= 4'd0;
      lives     <= 2'(INIT_LIVES);
      grace_cnt <= '0;
      game_over <= 1'b0;
      idx       <= 4'd0;
      found     <= 1'b0;
      found_idx <= 4'd0;
    end else if (restart) begin
      state     <= IDLE;
      busy      <= 1'b0;
      scan_done <= 1'b0;
      hit       <= 1'b0;
      hit_index <= 4'd0;
      lives     <= 2'(INIT_LIVES);
      grace_cnt <= '0;
      game_over <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      hit       <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start && !game_over) begin
            state <= SNAP;
            busy  <= 1'b1;
          end
        end
        SNAP: begin
          idx       <= 4'd0;
          found     <= 1'b0;
          found_idx <= 4'd0;
          state     <= SCAN;
        end
        SCAN: begin
          if (overlap && !found) begin
            found     <= 1'b1;
            found_idx <= idx;
          end
          if (idx == 4'(NUM_OBSTACLES - 1)) begin
            // The last slot's result is folded in here so the verdict lands with scan_done.
            state     <= DONE;
            busy      <= 1'b0;
            scan_done <= 1'b1;
            if (found || overlap) begin
              hit_index <= found ? found_idx : idx;
              if (grace_cnt == '0) begin
                hit       <= 1'b1;
                grace_cnt <= GW'(GRACE_FRAMES);
                if (lives == 2'd1) begin
                  lives     <= 2'd0;
                  game_over <= 1'b1;
                end else if (lives != 2'd0) begin
                  lives <= lives - 2'd1;
                end
              end else begin
                grace_cnt <= grace_cnt - GW'(1);
              end
            end else if (grace_cnt != '0) begin
              grace_cnt <= grace_cnt - GW'(1);
            end
          end else begin
            idx <= idx + 4'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_collision_checker.sv
// tb/tb_obstacle_collision_checker.sv - directed and randomized bench for obstacle_collision_checker
module tb_obstacle_collision_checker;
  localparam int N = 10;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                frame_start = 1'b0;
  logic                restart = 1'b0;
  logic [N-1:0][19:0]  obstacle_x;
  logic [N-1:0][17:0]  obstacle_y;
  logic [9:0]          player_x;
  logic [8:0]          player_y;
  logic                busy, scan_done, hit, grace_active, game_over;
  logic [3:0]          hit_index;
  logic [1:0]          lives;

  int checks = 0;
  int errors = 0;
  int ol[N], orr[N], ot[N], ob[N];
  int px, py;
  int m_lives, m_grace, m_go, m_idx;
  logic last_hit;

  always #5 clk = ~clk;

  obstacle_collision_checker dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .restart(restart),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
    .player_x(player_x), .player_y(player_y),
    .busy(busy), .scan_done(scan_done), .hit(hit), .hit_index(hit_index),
    .lives(lives), .grace_active(grace_active), .game_over(game_over)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      obstacle_x[i] = {10'(ol[i]), 10'(orr[i])};
      obstacle_y[i] = {9'(ot[i]), 9'(ob[i])};
    end
    player_x = 10'(px);
    player_y = 9'(py);
  endtask

  task automatic clear_slots();
    for (int i = 0; i < N; i++) begin
      ol[i] = 700; orr[i] = 700; ot[i] = 500; ob[i] = 500;
    end
  endtask

  function automatic int ref_first();
    for (int i = 0; i < N; i++)
      if (ol[i] < 640 && px < orr[i] && px + 32 > ol[i] && py < ob[i] && py + 32 > ot[i])
        return i;
    return -1;
  endfunction

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    m_lives = 3; m_grace = 0; m_go = 0; m_idx = 0;
  endtask

  task automatic run_frame(input string tag);
    int f, lat;
    logic exp_hit;
    apply();
    f = ref_first();
    exp_hit = 1'b0;
    last_hit = 1'b0;
    if (m_go != 0) begin
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      for (int c = 0; c < 14; c++) begin
        check({tag, " ignored busy"}, busy, 0);
        check({tag, " ignored scan_done"}, scan_done, 0);
        tick();
      end
      return;
    end
    if (f >= 0) begin
      m_idx = f;
      if (m_grace == 0) begin
        exp_hit = 1'b1; m_lives--; m_grace = 60;
        if (m_lives == 0) m_go = 1;
      end else m_grace--;
    end else if (m_grace > 0) m_grace--;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    lat = 1;
    while (!scan_done && lat < 20) begin
      check({tag, " busy"}, busy, 1);
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, 12);
    check({tag, " busy in done"}, busy, 0);
    check({tag, " hit"}, hit, exp_hit);
    check({tag, " hit_index"}, hit_index, m_idx);
    check({tag, " lives"}, lives, m_lives);
    check({tag, " grace_active"}, grace_active, m_grace != 0);
    check({tag, " game_over"}, game_over, m_go);
    last_hit = hit;
    tick();
    check({tag, " scan_done pulse"}, scan_done, 0);
  endtask

  initial begin
    int cnt, at, obs_idx;
    logic obs_hit;
    int hq[$];

    px = 100; py = 200;
    clear_slots();
    apply();
    tick(); tick();
    check("reset busy", busy, 0);
    check("reset scan_done", scan_done, 0);
    check("reset hit", hit, 0);
    check("reset hit_index", hit_index, 0);
    check("reset lives", lives, 3);
    check("reset grace", grace_active, 0);
    check("reset game_over", game_over, 0);
    rst_n = 1'b1;
    m_lives = 3; m_grace = 0; m_go = 0; m_idx = 0;
    tick();

    // basic hit on slot 0
    ol[0] = 120; orr[0] = 150; ot[0] = 210; ob[0] = 260;
    run_frame("basic");
    check("basic lives value", lives, 2);

    do_restart();
    check("restart lives", lives, 3);
    check("restart hit_index", hit_index, 0);
    check("restart grace", grace_active, 0);

    // touching edge on slot 3 does not count; slot 7 does
    clear_slots();
    ol[3] = 132; orr[3] = 170; ot[3] = 200; ob[3] = 240;
    ol[7] = 110; orr[7] = 140; ot[7] = 190; ob[7] = 220;
    run_frame("touch");
    check("touch index value", hit_index, 7);
    do_restart();

    clear_slots();
    ol[2] = 90;  orr[2] = 110; ot[2] = 220; ob[2] = 230;
    ol[5] = 125; orr[5] = 200; ot[5] = 150; ob[5] = 205;
    run_frame("lowest");
    check("lowest index value", hit_index, 2);
    do_restart();

    clear_slots();
    ol[4] = 700; orr[4] = 1000; ot[4] = 0; ob[4] = 500;
    run_frame("offscreen");
    check("offscreen hit value", hit, 0);

    // dropped second frame_start and input change after snapshot
    do_restart();
    clear_slots();
    ol[1] = 90; orr[1] = 140; ot[1] = 190; ob[1] = 230;
    apply();
    cnt = 0; at = 0; obs_idx = 0; obs_hit = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (c == 3) begin
        clear_slots();
        ol[6] = 90; orr[6] = 140; ot[6] = 190; ob[6] = 230;
        apply();
      end
      if (c == 5) frame_start = 1'b1;
      if (c == 6) frame_start = 1'b0;
      if (scan_done) begin
        cnt++; at = c; obs_idx = hit_index; obs_hit = hit;
      end
      tick();
    end
    m_idx = 1; m_lives = 2; m_grace = 60;
    check("drop scan count", cnt, 1);
    check("drop scan latency", at, 12);
    check("snapshot index", obs_idx, 1);
    check("snapshot hit", obs_hit, 1);
    check("snapshot lives", lives, 2);

    // overlap held every frame
    do_restart();
    clear_slots();
    ol[0] = 120; orr[0] = 150; ot[0] = 210; ob[0] = 260;
    for (int fr = 1; fr <= 130; fr++) begin
      run_frame("held");
      if (last_hit) hq.push_back(fr);
    end
    check("held hit count", hq.size(), 3);
    if (hq.size() == 3) begin
      check("held hit frame a", hq[0], 1);
      check("held hit frame b", hq[1], 62);
      check("held hit frame c", hq[2], 123);
    end
    check("held lives", lives, 0);
    check("held game_over", game_over, 1);

    do_restart();
    check("go restart lives", lives, 3);
    check("go restart game_over", game_over, 0);

    // restart aborts an in-flight scan
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    do_restart();
    check("abort busy", busy, 0);
    check("abort lives", lives, 3);
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (scan_done) cnt++;
      tick();
    end
    check("abort no scan_done", cnt, 0);
    check("abort lives after", lives, 3);

    // restart wins over coincident frame_start
    frame_start = 1'b1; restart = 1'b1;
    tick();
    frame_start = 1'b0; restart = 1'b0;
    m_lives = 3; m_grace = 0; m_go = 0; m_idx = 0;
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (busy || scan_done) cnt++;
      tick();
    end
    check("coincident no scan", cnt, 0);

    // randomized frames against the reference model
    for (int fr = 0; fr < 40; fr++) begin
      if (m_go != 0 || $urandom_range(0, 3) == 0) do_restart();
      px = int'($urandom_range(0, 600));
      py = int'($urandom_range(0, 440));
      for (int i = 0; i < N; i++) begin
        ol[i] = px - 50 + int'($urandom_range(0, 120));
        if ($urandom_range(0, 4) == 0) ol[i] = int'($urandom_range(600, 900));
        if (ol[i] < 0) ol[i] = 0;
        orr[i] = ol[i] + int'($urandom_range(0, 60));
        if (orr[i] > 1023) orr[i] = 1023;
        ot[i] = py - 50 + int'($urandom_range(0, 120));
        if (ot[i] < 0) ot[i] = 0;
        if (ot[i] > 511) ot[i] = 511;
        ob[i] = ot[i] + int'($urandom_range(0, 60));
        if (ob[i] > 511) ob[i] = 511;
      end
      run_frame("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
